hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Issue-stage scoreboard placed between instruction fetch and the ID stage of the 8-bit core (16-bit instructions, 8 architectural registers).
- Tracks in-flight register writes with per-register countdown counters.
- Stalls fetch and injects a NOP into ID whenever an instruction would read, or improperly overtake a write to, a register whose result is not yet visible in the register file.
- Replaces the hand-inserted NOP padding that programs need today.

Parameters:
- REG_ADDR_W, 3, register index width; the block tracks 2**REG_ADDR_W registers.
- WB_LATENCY, 3, cycles from issue (instr_out registered) until the ALU/LDI result is readable from the register file.
- LOAD_EXTRA, 1, additional cycles added for LDD results.
- ZERO_REG, 0, when 1, register 0 is never tracked and never causes a stall.
- STALL_CNT_W, 16, width of the saturating stall statistics counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset: asynchronous, active-low
- instr_in  in  16  instruction from fetch
- instr_valid  in  1  instr_in is meaningful this cycle
- instr_out  out  16  registered instruction to the ID stage (NOP when stalled)
- stall  out  1  combinational; fetch must hold instr_in while it is high
- busy  out  1  registered; high while any scoreboard counter is non-zero
- illegal  out  1  registered one-cycle pulse when an unknown opcode is issued
- stall_count  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Decode fields: op=[15:11], rd=[10:8], rs=[7:5].
- Source registers per opcode:
  - R2 (ADD 10000, SUB 10001, AND 10010, OR 10011, EOR 10110): rd and rs.
  - I-type (ADDI 01000, SUBI 01001, ANDI 01010, ORI 01011): rd.
  - R1 (NOT 11100, SHL 11101, SHR 11110): rd.
  - STD 01110: [10:8].
  - LDI 01100, LDD 01101, NOP 00101: none.
- Destination registers: R2, I-type, R1, LDI and LDD write rd. STD and NOP write nothing.
- Issue latency: new latency is lat = WB_LATENCY for writers, or WB_LATENCY + LOAD_EXTRA for LDD.
- Stall condition (combinational): instr_valid is high and either
  - any source register has cnt != 0 (RAW), or
  - the destination register has cnt > lat (WAW ordering).
- Stall is forced to 0 while rst is low.
- Each rising clk edge:
  - All non-zero counters decrement by 1.
  - If instr_valid is high and there is no stall: instr_out <= instr_in, and cnt[rd] <= lat for writers. Set takes priority over decrement on the same register.
  - If stall is high or instr_valid is low: instr_out <= 16'h2800 (NOP).
- Counter width is clog2(WB_LATENCY+LOAD_EXTRA+1). The counter saturates at 0 and never wraps.
- An unknown opcode is issued as-is, with no source and no destination; illegal pulses high for one cycle.
- stall_count increments on each cycle where stall is high and holds at its all-ones value.
- Reset (asynchronous assert, in any state, including mid-stall):
  - all counters = 0
  - instr_out = 16'h2800
  - busy = 0, illegal = 0, stall_count = 0
  - in-flight writes are forgotten; the pipeline is reset alongside this block.
- The ZERO_REG=1 exemption applies to both source and destination checks.

Decomposition:
- Shared package (isa_pkg): opcode localparams (OP_ADD..OP_SHR, OP_NOP, OP_LDI, OP_LDD, OP_STD), NOP_INSTR = 16'h2800, and field bit-position constants. This package is also used by the ID stage.
- One sub-module, instr_reg_usage: purely combinational. Inputs are the instruction; outputs are src1_en, src1, src2_en, src2, dst_en, dst, is_load and is_illegal.
- The scoreboard counter array and the stall logic stay in the top module.

Test Plan:
- Reset check: hold rst low for 1 cycle, then release -> instr_out=16'h2800, stall=0, busy=0, stall_count=0.
- RAW on ALU result: LDI X1,51 at t0, then ADD X2,X1 presented immediately -> stall=1 for exactly 3 cycles, then ADD issued; stall_count=3.
- Load-use: LDD X1,[1] followed by STD X1,[5] -> 4 stall cycles. With LOAD_EXTRA=0 the same sequence gives 3 stall cycles.
- Independent stream: LDI X1; LDI X2; ANDI X3,1 with no overlap -> zero stalls; instr_out is each instruction delayed by 1 cycle.
- WAW ordering: LDD X4 then ADDI X4,1 on the next cycle -> ADDI stalls until cnt[4] <= 3, i.e. 1 stall cycle (it also reads X4, so the RAW condition extends this to 3 further cycles: 4 stall cycles in total).
- Reset mid-stall plus illegal opcode: assert rst during the second stall cycle -> counters cleared, stall=0 the following cycle. Then opcode 11111 -> issued unchanged with illegal=1 for one cycle.

Source files
------------

// File: rtl/isa_pkg.sv
// Instruction-set constants for the 8-bit core: opcodes, the canonical NOP and field positions.
// The scoreboard and the ID stage both use this package.
package isa_pkg;
    localparam logic [4:0] OP_ADD  = 5'b10000;
    localparam logic [4:0] OP_SUB  = 5'b10001;
    localparam logic [4:0] OP_AND  = 5'b10010;
    localparam logic [4:0] OP_OR   = 5'b10011;
    localparam logic [4:0] OP_EOR  = 5'b10110;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_SUBI = 5'b01001;
    localparam logic [4:0] OP_ANDI = 5'b01010;
    localparam logic [4:0] OP_ORI  = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b11100;
    localparam logic [4:0] OP_SHL  = 5'b11101;
    localparam logic [4:0] OP_SHR  = 5'b11110;
    localparam logic [4:0] OP_STD  = 5'b01110;
    localparam logic [4:0] OP_LDI  = 5'b01100;
    localparam logic [4:0] OP_LDD  = 5'b01101;
    localparam logic [4:0] OP_NOP  = 5'b00101;

    localparam logic [15:0] NOP_INSTR = 16'h2800;

    localparam int OP_LSB = 11;
    localparam int RD_LSB = 8;
    localparam int RS_LSB = 5;
endpackage

// File: rtl/instr_reg_usage.sv
// Combinational decode of which registers an instruction reads and writes.
// src1 is the rd field (also the STD source), src2 is the rs field.
module instr_reg_usage
    import isa_pkg::*;
#(
    parameter int REG_ADDR_W = 3
) (
    input  logic [15:0]           instr,
    output logic                  src1_en,
    output logic [REG_ADDR_W-1:0] src1,
    output logic                  src2_en,
    output logic [REG_ADDR_W-1:0] src2,
    output logic                  dst_en,
    output logic [REG_ADDR_W-1:0] dst,
    output logic                  is_load,
    output logic                  is_illegal
);
    logic [4:0] op;
    logic       unused_imm;

    assign op         = instr[OP_LSB +: 5];
    assign src1       = instr[RD_LSB +: REG_ADDR_W];
    assign src2       = instr[RS_LSB +: REG_ADDR_W];
    assign dst        = instr[RD_LSB +: REG_ADDR_W];
    assign unused_imm = ^instr[4:0];

    always_comb begin
        src1_en    = 1'b0;
        src2_en    = 1'b0;
        dst_en     = 1'b0;
        is_load    = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EOR: begin
                src1_en = 1'b1;
                src2_en = 1'b1;
                dst_en  = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_NOT, OP_SHL, OP_SHR: begin
                src1_en = 1'b1;
                dst_en  = 1'b1;
            end
            OP_STD: src1_en = 1'b1;
            OP_LDI: dst_en = 1'b1;
            OP_LDD: begin
                dst_en  = 1'b1;
                is_load = 1'b1;
            end
            OP_NOP: ;
            default: is_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage scoreboard: per-register countdown of in-flight writes; stalls fetch and
// feeds a NOP to ID while an instruction would read or overtake a result not yet written back.
module hazard_scoreboard
    import isa_pkg::*;
#(
    parameter int REG_ADDR_W  = 3,
    parameter int WB_LATENCY  = 3,
    parameter int LOAD_EXTRA  = 1,
    parameter int ZERO_REG    = 0,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            instr_in,
    input  logic                   instr_valid,
    output logic [15:0]            instr_out,
    output logic                   stall,
    output logic                   busy,
    output logic                   illegal,
    output logic [STALL_CNT_W-1:0] stall_count
);
    localparam int NREG  = 2 ** REG_ADDR_W;
    localparam int CNT_W = $clog2(WB_LATENCY + LOAD_EXTRA + 1);
    localparam logic [CNT_W-1:0] LAT_ALU = CNT_W'(WB_LATENCY);
    localparam logic [CNT_W-1:0] LAT_LDD = CNT_W'(WB_LATENCY + LOAD_EXTRA);

    logic [CNT_W-1:0]      cnt      [NREG];
    logic [CNT_W-1:0]      cnt_next [NREG];
    logic                  src1_en, src2_en, dst_en, is_load, is_illegal;
    logic [REG_ADDR_W-1:0] src1, src2, dst;
    logic [CNT_W-1:0]      lat;
    logic                  raw, waw, issue, any_busy;

    instr_reg_usage #(.REG_ADDR_W(REG_ADDR_W)) u_usage (
        .instr      (instr_in),
        .src1_en    (src1_en),
        .src1       (src1),
        .src2_en    (src2_en),
        .src2       (src2),
        .dst_en     (dst_en),
        .dst        (dst),
        .is_load    (is_load),
        .is_illegal (is_illegal)
    );

    // With ZERO_REG set, register 0 is hardwired and never participates in hazards.
    function automatic logic tracked(input logic [REG_ADDR_W-1:0] r);
        return !((ZERO_REG != 0) && (r == '0));
    endfunction

    assign lat   = is_load ? LAT_LDD : LAT_ALU;
    assign raw   = (src1_en && tracked(src1) && (cnt[src1] != '0)) ||
                   (src2_en && tracked(src2) && (cnt[src2] != '0));
    assign waw   = dst_en && tracked(dst) && (cnt[dst] > lat);
    assign stall = rst && instr_valid && (raw || waw);
    assign issue = instr_valid && !stall;

    always_comb begin
        any_busy = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            cnt_next[i] = cnt[i];
            if (issue && dst_en && tracked(dst) && (dst == REG_ADDR_W'(i)))
                cnt_next[i] = lat;
            else if (cnt[i] != '0)
                cnt_next[i] = cnt[i] - 1'b1;
            any_busy = any_busy | (cnt_next[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
            instr_out   <= NOP_INSTR;
            busy        <= 1'b0;
            illegal     <= 1'b0;
            stall_count <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) cnt[i] <= cnt_next[i];
            instr_out <= issue ? instr_in : NOP_INSTR;
            busy      <= any_busy;
            illegal   <= issue && is_illegal;
            if (stall && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed hazard scenarios plus randomized instruction streams against a ready-time model.
module tb_hazard_scoreboard;
    import isa_pkg::*;

    localparam int WB = 3;
    localparam int LX = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr_in = NOP_INSTR;
    logic        instr_valid = 1'b0;
    logic [15:0] instr_out;
    logic        stall, busy, illegal;
    logic [15:0] stall_count;

    hazard_scoreboard #(
        .REG_ADDR_W(3), .WB_LATENCY(WB), .LOAD_EXTRA(LX), .ZERO_REG(0), .STALL_CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_out(instr_out), .stall(stall), .busy(busy), .illegal(illegal),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: ready[r] is the cycle index at which register r becomes readable.
    int          t = 0;
    int          ready[8];
    logic [15:0] m_out = NOP_INSTR;
    logic        m_ill = 1'b0;
    int          m_scnt = 0;

    function automatic void usage(input logic [15:0] i, output bit rd_rd, output bit rd_rs,
                                  output bit wr, output bit unk);
        logic [4:0] op;
        op = i[15:11];
        rd_rd = 0; rd_rs = 0; wr = 0; unk = 0;
        if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EOR}) begin
            rd_rd = 1; rd_rs = 1; wr = 1;
        end else if (op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_NOT, OP_SHL, OP_SHR}) begin
            rd_rd = 1; wr = 1;
        end else if (op == OP_STD) rd_rd = 1;
        else if (op == OP_LDI || op == OP_LDD) wr = 1;
        else if (op != OP_NOP) unk = 1;
    endfunction

    function automatic int lat_of(input logic [15:0] i);
        return (i[15:11] == OP_LDD) ? WB + LX : WB;
    endfunction

    function automatic bit model_stall(input logic [15:0] i, input logic v);
        bit a, b, w, u;
        if (!v) return 0;
        usage(i, a, b, w, u);
        if (a && ready[i[10:8]] > t) return 1;
        if (b && ready[i[7:5]] > t) return 1;
        if (w && ready[i[10:8]] - t > lat_of(i)) return 1;
        return 0;
    endfunction

    function automatic bit model_busy();
        for (int r = 0; r < 8; r++) if (ready[r] > t) return 1;
        return 0;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 8; r++) ready[r] = 0;
        m_out = NOP_INSTR; m_ill = 0; m_scnt = 0;
    endfunction

    // Entered 1 time unit after a rising edge; returns the DUT's observed stall.
    task automatic cycle(input logic [15:0] i, input logic v, output bit s);
        bit ms, a, b, w, u;
        instr_in = i; instr_valid = v;
        #4;
        ms = model_stall(i, v);
        check("stall", stall, ms);
        s = stall;
        usage(i, a, b, w, u);
        @(posedge clk); #1;
        t++;
        if (v && !ms) begin
            m_out = i; m_ill = u;
            if (w) ready[i[10:8]] = t + lat_of(i);
        end else begin
            m_out = NOP_INSTR; m_ill = 0;
        end
        if (ms && m_scnt != 65535) m_scnt++;
        check("instr_out", instr_out, m_out);
        check("illegal", illegal, m_ill);
        check("busy", busy, model_busy());
        check("stall_count", stall_count, m_scnt);
    endtask

    task automatic issue(input logic [15:0] i, output int n);
        bit s;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(i, 1'b1, s);
            if (!s) return;
            n++;
        end
        check("issue_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        bit s;
        for (int k = 0; k < 6; k++) cycle(NOP_INSTR, 1'b0, s);
    endtask

    task automatic reset_pulse();
        rst = 1'b0; instr_valid = 1'b0;
        #1;
        model_clear();
        check("rst_instr_out", instr_out, NOP_INSTR);
        check("rst_stall", stall, 0);
        check("rst_busy", busy, 0);
        check("rst_stall_count", stall_count, 0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    localparam logic [4:0] RAND_OPS [18] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EOR, OP_ADDI,
        OP_SUBI, OP_ANDI, OP_ORI, OP_NOT, OP_SHL, OP_SHR, OP_STD, OP_LDI, OP_LDD, OP_NOP,
        5'b11111, 5'b00000};

    initial begin
        int n;
        bit s;
        logic [15:0] ri;
        logic [4:0]  op;

        // Reset check
        @(posedge clk); #1;
        reset_pulse();
        cycle(NOP_INSTR, 1'b0, s);

        // RAW on ALU result
        issue({OP_LDI, 3'd1, 8'd51}, n);
        check("raw_ldi_stalls", n, 0);
        issue({OP_ADD, 3'd2, 3'd1, 5'd0}, n);
        check("raw_add_stalls", n, 3);
        check("raw_stall_count", stall_count, 3);
        drain();

        // Load-use
        issue({OP_LDD, 3'd1, 8'd1}, n);
        issue({OP_STD, 3'd1, 8'd5}, n);
        check("load_use_stalls", n, 4);
        drain();

        // Independent stream
        issue({OP_LDI, 3'd1, 8'd7}, n);
        check("indep_1", n, 0);
        issue({OP_LDI, 3'd2, 8'd9}, n);
        check("indep_2", n, 0);
        issue({OP_ANDI, 3'd3, 8'd1}, n);
        check("indep_3", n, 0);
        drain();

        // WAW ordering combined with RAW
        issue({OP_LDD, 3'd4, 8'd2}, n);
        issue({OP_ADDI, 3'd4, 8'd1}, n);
        check("waw_stalls", n, 4);
        drain();

        // Reset in the second stall cycle, then an unknown opcode
        cycle({OP_LDI, 3'd1, 8'd3}, 1'b1, s);
        cycle({OP_ADD, 3'd2, 3'd1, 5'd0}, 1'b1, s);
        check("pre_reset_stall", s, 1);
        rst = 1'b0;
        #1;
        model_clear();
        check("midrst_stall", stall, 0);
        check("midrst_instr_out", instr_out, NOP_INSTR);
        check("midrst_busy", busy, 0);
        check("midrst_stall_count", stall_count, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        cycle({OP_ADD, 3'd2, 3'd1, 5'd0}, 1'b1, s);
        check("post_reset_stall", s, 0);
        cycle(16'hF9A5, 1'b1, s);
        check("illegal_pulse", illegal, 1);
        check("illegal_out", instr_out, 16'hF9A5);
        cycle(NOP_INSTR, 1'b0, s);
        check("illegal_drop", illegal, 0);

        // Randomized stream, holding the instruction while stalled
        for (int k = 0; k < 600; k++) begin
            op = RAND_OPS[$urandom_range(0, 17)];
            ri = {op, 11'($urandom)};
            if ($urandom_range(0, 9) < 8) begin
                issue(ri, n);
            end else begin
                cycle(ri, 1'b0, s);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
